// File: rtl/amo_unit_mc.sv
// Atomic memory operation unit for N cores: bypasses plain loads/stores, runs AMOs
// as read-modify-write on one 32-bit lane, and tracks one LR/SC reservation per core.
module amo_unit_mc #(
  parameter int N           = 2,
  parameter int XLEN        = 32,
  parameter int CLSIZE      = 128,
  parameter int RSV_GRAN    = 5,
  parameter int RSV_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      core_id_i,
  input  logic              core_strobe_i,
  input  logic [XLEN-1:0]   core_addr_i,
  input  logic              core_rw_i,
  input  logic [CLSIZE-1:0] core_data_i,
  output logic              core_done_o,
  output logic [CLSIZE-1:0] core_data_o,
  input  logic              core_is_amo_i,
  input  logic [4:0]        core_amo_type_i,
  output logic              M_DMEM_strobe_o,
  output logic [XLEN-1:0]   M_DMEM_addr_o,
  output logic              M_DMEM_rw_o,
  output logic [CLSIZE-1:0] M_DMEM_data_o,
  input  logic              M_DMEM_done_i,
  input  logic [CLSIZE-1:0] M_DMEM_data_i
);

  localparam int OFF = $clog2(CLSIZE / 8);
  localparam int LW  = OFF - 2;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int TCW = (RSV_TIMEOUT > 0) ? $clog2(RSV_TIMEOUT + 1) : 1;
  localparam int GW  = XLEN - RSV_GRAN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  // SWAP, SC and every unlisted code store rs2.
  function automatic logic [31:0] amo_alu(input logic [4:0]  f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f)
      F_ADD:   amo_alu = a + b;
      F_XOR:   amo_alu = a ^ b;
      F_OR:    amo_alu = a | b;
      F_AND:   amo_alu = a & b;
      F_MIN:   amo_alu = (sa < sb) ? a : b;
      F_MAX:   amo_alu = (sa > sb) ? a : b;
      F_MINU:  amo_alu = (a < b) ? a : b;
      F_MAXU:  amo_alu = (a > b) ? a : b;
      default: amo_alu = b;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic              sc_fail_q, sc_fail_d;
  logic [CLSIZE-1:0] mbuf_q, mbuf_d;
  logic [N-1:0]      rv_q, rv_d;
  logic [GW-1:0]     ra_q [N];
  logic [GW-1:0]     ra_d [N];
  logic [TCW-1:0]    tc_q [N];
  logic [TCW-1:0]    tc_d [N];

  logic [LW-1:0]     lane;
  logic [CW-1:0]     cid;
  logic [GW-1:0]     gran;
  logic [31:0]       rs1, rs2, alu_res;
  logic              is_lr, is_sc, sc_fail_now, fin_amo, wrote_mem;
  logic [CLSIZE-1:0] wr_line, ret_line;

  assign lane    = core_addr_i[OFF-1:2];
  assign gran    = core_addr_i[XLEN-1:RSV_GRAN];
  assign rs1     = mbuf_q[{lane, 5'b00000} +: 32];
  assign rs2     = core_data_i[{lane, 5'b00000} +: 32];
  assign alu_res = amo_alu(core_amo_type_i, rs1, rs2);
  assign is_lr   = (core_amo_type_i == F_LR);
  assign is_sc   = (core_amo_type_i == F_SC);

  // Lowest set id bit wins; an all-zero id falls through to core 0.
  always_comb begin
    cid = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (core_id_i[i]) cid = CW'(i);
    end
  end

  assign sc_fail_now = ~rv_q[cid] | (ra_q[cid] != gran);

  // ---- sequencer: IDLE -> RD -> WR -> FIN ----
  always_comb begin
    state_d   = state_q;
    sc_fail_d = sc_fail_q;
    mbuf_d    = mbuf_q;
    case (state_q)
      S_IDLE: begin
        if (core_strobe_i && core_is_amo_i) begin
          sc_fail_d = is_sc && sc_fail_now;
          state_d   = (is_sc && sc_fail_now) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        if (M_DMEM_done_i) begin
          mbuf_d  = M_DMEM_data_i;
          state_d = is_lr ? S_FIN : S_WR;
        end
      end
      S_WR: begin
        if (M_DMEM_done_i) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_line = mbuf_q;
    wr_line[{lane, 5'b00000} +: 32] = alu_res;
  end

  always_comb begin
    ret_line = '0;
    ret_line[{lane, 5'b00000} +: 32] = is_sc ? {31'b0, sc_fail_q} : rs1;
  end

  // ---- memory / core port muxing ----
  assign M_DMEM_addr_o   = core_addr_i;
  assign M_DMEM_strobe_o = core_is_amo_i ? ((state_q == S_RD) || (state_q == S_WR)) : core_strobe_i;
  assign M_DMEM_rw_o     = core_is_amo_i ? (state_q == S_WR) : core_rw_i;
  assign M_DMEM_data_o   = core_is_amo_i ? wr_line : core_data_i;
  assign core_done_o     = core_is_amo_i ? (state_q == S_FIN) : M_DMEM_done_i;
  assign core_data_o     = core_is_amo_i ? ret_line : M_DMEM_data_i;

  assign fin_amo   = (state_q == S_FIN) && core_is_amo_i;
  assign wrote_mem = core_done_o &&
                     (core_is_amo_i ? (!is_lr && !(is_sc && sc_fail_q))
                                    : (core_strobe_i && core_rw_i));

  // ---- reservations: timeout, write snooping, then LR/SC of the requester ----
  always_comb begin
    rv_d = rv_q;
    ra_d = ra_q;
    tc_d = tc_q;
    for (int k = 0; k < N; k++) begin
      if (RSV_TIMEOUT > 0 && rv_q[k]) begin
        if (tc_q[k] == TCW'(RSV_TIMEOUT)) begin
          rv_d[k] = 1'b0;
          tc_d[k] = '0;
        end else begin
          tc_d[k] = tc_q[k] + TCW'(1);
        end
      end
      if (wrote_mem && ra_q[k] == gran) rv_d[k] = 1'b0;
    end
    if (fin_amo && is_sc) rv_d[cid] = 1'b0;
    if (fin_amo && is_lr) begin
      rv_d[cid] = 1'b1;
      ra_d[cid] = gran;
      tc_d[cid] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      sc_fail_q <= 1'b0;
      rv_q      <= '0;
      for (int k = 0; k < N; k++) begin
        ra_q[k] <= '0;
        tc_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sc_fail_q <= sc_fail_d;
      rv_q      <= rv_d;
      ra_q      <= ra_d;
      tc_q      <= tc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mbuf_q <= mbuf_d;
  end

endmodule

// File: doc/amo_unit_mc.md
# amo_unit_mc

Multi-core atomic memory operation unit that sits between the arbitrated core data port and the data memory/cache port. Plain loads and stores pass straight through. AMOs are executed as a read-modify-write sequence, and LR/SC is implemented with one reservation per core. This generation generalises the previous unit in four ways:
- any core count N;
- any 32-bit word lane within the cache line;
- a parametrised reservation granule;
- a per-core reservation timeout.

## Interface
Parameters:
- N, 2, number of cores; core_id_i is one-hot over N.
- XLEN, 32, address width.
- CLSIZE, 128, cache-line width in bits; a multiple of 32 and at least 64.
- RSV_GRAN, 5, log2 of the reservation granule in bytes; must satisfy 2 ≤ RSV_GRAN < XLEN.
- RSV_TIMEOUT, 255, reservation lifetime in cycles; 0 disables the timeout.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  reset; synchronous, active-high.
- core_id_i  in  N  one-hot requester id.
- core_strobe_i  in  1  request valid; held until core_done_o.
- core_addr_i  in  XLEN  byte address.
- core_rw_i  in  1  1 = write.
- core_data_i  in  CLSIZE  write line; for AMO/SC, rs2 sits in the addressed lane.
- core_done_o  out  1  request complete.
- core_data_o  out  CLSIZE  read line or AMO result.
- core_is_amo_i  in  1  request is AMO/LR/SC.
- core_amo_type_i  in  5  funct5: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100; any other code behaves as SWAP.
- M_DMEM_strobe_o, M_DMEM_addr_o [XLEN], M_DMEM_rw_o, M_DMEM_data_o [CLSIZE]  out  memory request.
- M_DMEM_done_i  in  1; M_DMEM_data_i  in  CLSIZE  memory response.

## Operation
- **Lane select.** L = core_addr_i[log2(CLSIZE/8)-1:2]; lane L occupies bits [32L+31:32L].
  - rs1 = memory lane L; rs2 = core_data_i lane L.
- **Id decode.** The lowest set bit of core_id_i selects the core; all-zero maps to core 0.
- **FSM states:** IDLE, RD, WR, FIN; reset state is IDLE.
  - IDLE with core_strobe_i & core_is_amo_i:
    - SC with fail → FIN;
    - otherwise → RD.
  - RD:
    - on M_DMEM_done_i, capture M_DMEM_data_i into line buffer mbuf;
    - then LR → FIN, else → WR.
  - WR:
    - M_DMEM_rw_o = 1 and M_DMEM_data_o = mbuf with lane L replaced by result;
    - on M_DMEM_done_i → FIN.
  - FIN: core_done_o = 1 for exactly one cycle, then → IDLE.
- **Bypass.** When core_is_amo_i = 0, strobe, rw, data and done connect combinationally between core and memory. M_DMEM_addr_o = core_addr_i always.
- **AMO return data.** core_data_o carries the result in lane L with all other bits 0:
  - SC: returns the fail flag (0 = success, 1 = fail);
  - all other AMOs and LR: return rs1.
- **ALU.** 32-bit operations with wrap-around ADD.
  - MIN/MAX compare signed.
  - MINU/MAXU compare unsigned.
  - SC writes rs2.
- **Reservations.** Per core c: valid bit rv[c], granule address ra[c] = addr[XLEN-1:RSV_GRAN], and counter tc[c].
  - An LR completing in FIN sets rv, loads ra and clears tc.
  - A second LR from the same core replaces the reservation.
- **SC fail condition.** ~rv[c] | (ra[c] != addr[XLEN-1:RSV_GRAN]), evaluated combinationally.
- **Clearing a reservation.** On each core_done_o:
  - the requester's rv is cleared if the request is an SC, whether it passes or fails;
  - every rv[k] with matching ra[k] is cleared if the request wrote memory: a bypass write, an AMO, or a successful SC.
- **Timeout.** When RSV_TIMEOUT > 0, tc[c] increments every cycle while rv[c] = 1. When tc[c] reaches RSV_TIMEOUT, rv[c] clears on the next edge.

## Timing
- **Reset values.** State IDLE, all rv = 0, all tc = 0, all ra = 0.
  - With core_is_amo_i = 1: M_DMEM_strobe_o = 0, M_DMEM_rw_o = 0, core_done_o = 0.
  - With core_is_amo_i = 0: outputs follow bypass.
  - Reset mid-sequence drops M_DMEM_strobe_o from the next cycle; no done is generated.
- **Latency.** With the request accepted at cycle T and memory answering in the same cycle it is strobed:
  - AMO: done at T+3;
  - LR: done at T+2;
  - failed SC: done at T+1.
  - Each memory wait cycle adds one cycle.
  - Bypass adds 0 cycles.
- M_DMEM_strobe_o is high throughout RD and WR and is never high in FIN.
- **Simultaneous events.**
  - Timeout expiry in the same cycle an SC is evaluated in IDLE: the SC succeeds, because the old rv is still valid; expiry takes effect at the edge.
  - LR done and timeout in the same cycle: the LR wins and tc restarts.

## Test plan
- **AMOADD with N=2, CLSIZE=128.** Core 1 performs AMOADD at 0x108 (lane 2); memory lane 2 = 0x7FFFFFFF, rs2 = 1.
  - Write lane 2 = 0x80000000; other lanes unchanged.
  - core_data_o lane 2 = 0x7FFFFFFF; done at T+3.
- **LR/SC success.** Core 0 performs LR 0x40, then SC 0x44 with rs2 = 0xA5.
  - The SC writes 0xA5 and returns 0; rv[0] = 0 afterwards.
- **SC invalidated.** LR by core 0 at 0x40, then a bypass write by core 1 at 0x5C, then SC by core 0 at 0x40.
  - The SC returns 1 with no memory strobe; done at T+1.
- **Timeout expiry.** RSV_TIMEOUT = 4: LR, idle 6 cycles, SC to the same address.
  - The SC fails.
  - With only 2 idle cycles instead, the SC succeeds.
- **MIN/MINU operand handling.** rs1 = 0xFFFFFFFF, rs2 = 1.
  - MIN writes 0xFFFFFFFF; MINU writes 1.
  - Unknown funct5 10101 writes rs2.
- **Reset during WR.** Assert rst_i while the FSM is in WR.
  - Next cycle: strobe 0, state IDLE, all reservations cleared, no core_done_o.
